// File: rtl/pmod_als_sampler_if.sv
// Pin and result bundle for the PmodALS sampler.
// master: the sampler (drives cs/sck, publishes sample/sample_valid/busy).
// slave : the sensor/consumer side (drives sdo, observes everything else).
interface pmod_als_sampler_if;
    logic       cs;
    logic       sck;
    logic       sdo;
    logic [7:0] sample;
    logic       sample_valid;
    logic       busy;

    modport master (
        output cs,
        output sck,
        input  sdo,
        output sample,
        output sample_valid,
        output busy
    );

    modport slave (
        input  cs,
        input  sck,
        output sdo,
        input  sample,
        input  sample_valid,
        input  busy
    );
endinterface

// File: rtl/pmod_als_sampler.sv
// pmod_als_sampler: periodic SPI read of the PmodALS (ADC081S021) light sensor.
// Runs a 16-SCK frame every SAMPLE_PERIOD clocks and publishes the 8-bit level
// with a one-cycle valid strobe. Define ALS_AVG_EN to replace the raw level by
// a running average of the last four readings (one extra cycle of latency).
module pmod_als_sampler #(
    parameter int SCK_HALF      = 3,
    parameter int SAMPLE_PERIOD = 12000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    pmod_als_sampler_if.master als
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int PH_W  = $clog2(2 * SCK_HALF);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PH_W-1:0]  HALF_M1  = PH_W'(SCK_HALF - 1);
    localparam logic [PH_W-1:0]  FULL_M1  = PH_W'(2 * SCK_HALF - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [3:0]       bit_q, bit_d;
    // Only raw[12:0] is kept: the three leading zero bits shift straight out.
    logic [12:0]      shift_q, shift_d;
    logic             cs_q, cs_d;
    logic             sck_q, sck_d;
    logic             busy_q, busy_d;
    logic [7:0]       sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             data_load;

    // Frame sequencer: free-running period counter, SETUP/SHIFT/HOLD phases,
    // and pin levels derived from the next state so cs/sck come from flops.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_load = 1'b0;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if ((cnt_q == CNT_LAST) && enable) begin
                    state_d = ST_SETUP;
                    ph_d    = '0;
                end
            end
            ST_SETUP: begin
                if (ph_q == HALF_M1) begin
                    state_d = ST_SHIFT;
                    ph_d    = '0;
                    bit_d   = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // This edge is the one where sck goes low->high.
                if (ph_q == HALF_M1) begin
                    shift_d = {shift_q[11:0], als.sdo};
                end
                if (ph_q == FULL_M1) begin
                    ph_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d   = ST_HOLD;
                        data_load = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: begin
                if (ph_q == HALF_M1) begin
                    state_d = ST_IDLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
        endcase

        cs_d   = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
        sck_d  = !((state_d == ST_SHIFT) && (ph_d <= HALF_M1));
        busy_d = (state_d != ST_IDLE);
    end

`ifdef ALS_AVG_EN
    logic [7:0] data_q, data_d;
    logic       pend_q, pend_d;
    logic [7:0] hist_q [3];
    logic [7:0] hist_d [3];
    logic [9:0] avg_sum;

    // Average stage: latch the new byte, then sum it with three history bytes.
    always_comb begin
        data_d   = data_load ? shift_q[12:5] : data_q;
        pend_d   = data_load;
        avg_sum  = {2'b00, data_q} + {2'b00, hist_q[0]} +
                   {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
        sample_d = pend_q ? 8'(avg_sum >> 2) : sample_q;
        valid_d  = pend_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hist
            // History tap: advances one slot each time an average is produced.
            if (gi == 0) begin : g_head
                always_comb hist_d[gi] = pend_q ? data_q : hist_q[gi];
            end else begin : g_tail
                always_comb hist_d[gi] = pend_q ? hist_q[gi-1] : hist_q[gi];
            end

            // History storage; zeroed by reset so the first outputs ramp up.
            always_ff @(posedge clock) begin
                if (reset) begin
                    hist_q[gi] <= '0;
                end else begin
                    hist_q[gi] <= hist_d[gi];
                end
            end
        end
    endgenerate

    // Average stage pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end
`else
    // Unfiltered output: publish the data byte on HOLD entry.
    always_comb begin
        sample_d = data_load ? shift_q[12:5] : sample_q;
        valid_d  = data_load;
    end
`endif

    // Sequencer and output registers; reset drops any partial frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ph_q     <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b1;
            busy_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign als.cs           = cs_q;
    assign als.sck          = sck_q;
    assign als.busy         = busy_q;
    assign als.sample       = sample_q;
    assign als.sample_valid = valid_q;

endmodule

// File: tb/tb_pmod_als_sampler.sv
// Bench for pmod_als_sampler: sensor model on the SPI pins, scoreboard of
// expected light levels, and pin-timing monitor. Honours ALS_AVG_EN.
module tb_pmod_als_sampler;

    localparam int HALF   = 3;
    localparam int PERIOD = 200;
`ifdef ALS_AVG_EN
    localparam int LAT = 33 * HALF + 1;
`else
    localparam int LAT = 33 * HALF;
`endif

    logic clock = 1'b0;
    logic reset;
    logic enable;

    pmod_als_sampler_if als_if ();

    pmod_als_sampler #(
        .SCK_HALF      (HALF),
        .SAMPLE_PERIOD (PERIOD)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .als    (als_if)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Sensor model: random garbage around the data byte, new bit on each sck fall.
    logic [7:0]  model_data;
    logic [7:0]  frame_byte;
    logic [15:0] word;
    int          idx;

    always @(negedge als_if.cs) begin
        word       = {3'($urandom), model_data, 5'($urandom)};
        frame_byte = model_data;
        idx        = 15;
    end

    always @(negedge als_if.sck) begin
        if (als_if.cs === 1'b0) begin
            als_if.sdo = word[idx];
            idx        = idx - 1;
        end
    end

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [7:0] q [$];
    logic [7:0] hist [3];
    int frame_num   = 0;
    int abort_frame = -1;
    int n_valid     = 0;
    int rises       = 0;
    int cs_start    = 0;
    int rst_cyc     = 0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic p_cs, p_sck, p_valid, cs, sck, has;
        logic [7:0] raw, exp;
        int run;
        p_cs = 1'b1; p_sck = 1'b1; p_valid = 1'b0; run = 0;
        forever begin
            @(negedge clock);
            cs  = als_if.cs;
            sck = als_if.sck;
            if (p_cs === 1'b1 && cs === 1'b0) begin
                frame_num++;
                cs_start = cyc;
                run      = 1;
                rises    = 0;
                q.push_back(frame_byte);
                chk(32'(als_if.busy), 32'd1, "busy_at_cs_fall");
            end else if (cs === 1'b0) begin
                if (sck !== p_sck) begin
                    if (abort_frame != frame_num)
                        chk(32'(run), 32'(HALF), p_sck ? "sck_high_phase" : "sck_low_phase");
                    if (sck === 1'b1) rises++;
                    run = 1;
                end else begin
                    run++;
                end
            end else if (p_cs === 1'b0 && cs === 1'b1 && abort_frame != frame_num) begin
                chk(32'(run), 32'(HALF), "sck_last_high_phase");
                chk(32'(cyc - cs_start), 32'(33 * HALF), "cs_low_length");
                chk(32'(rises), 32'd16, "sck_rise_count");
            end
            if (als_if.sample_valid === 1'b1) begin
                chk(32'(p_valid), 32'd0, "valid_pulse_width");
                chk(32'(als_if.busy), 32'd1, "busy_at_valid");
                has = (q.size() != 0);
                chk(32'(has), 32'd1, "valid_has_expected");
                if (has) begin
                    raw = q.pop_front();
`ifdef ALS_AVG_EN
                    exp = 8'((10'(raw) + 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2])) >> 2);
                    hist[2] = hist[1];
                    hist[1] = hist[0];
                    hist[0] = raw;
`else
                    exp = raw;
`endif
                    chk(32'(als_if.sample), 32'(exp), "sample_value");
                    chk(32'(cyc - cs_start), 32'(LAT), "frame_to_valid_latency");
                    $display("txn %0d: data=%02h sample=%02h expected=%02h at cycle %0d",
                             n_valid, raw, als_if.sample, exp, cyc);
                end
                n_valid++;
            end
            p_cs = cs; p_sck = sck; p_valid = als_if.sample_valid;
        end
    endtask

    task automatic wait_valid(input string tag);
        int target, budget;
        target = n_valid + 1;
        budget = 2 * PERIOD + 50;
        while (n_valid < target && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        chk(32'(n_valid), 32'(target), tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
        repeat (3) @(negedge clock);
        chk(32'(als_if.cs), 32'd1, "reset_cs");
        chk(32'(als_if.sck), 32'd1, "reset_sck");
        chk(32'(als_if.sample), 32'd0, "reset_sample");
        chk(32'(als_if.sample_valid), 32'd0, "reset_valid");
        chk(32'(als_if.busy), 32'd0, "reset_busy");
        reset   = 1'b0;
        rst_cyc = cyc;
    endtask

    initial begin
        int f0, budget;
        reset      = 1'b1;
        enable     = 1'b1;
        model_data = 8'hA5;
        als_if.sdo = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
        fork
            monitor();
        join_none

        // Reset values, then first frame lands exactly one period after reset.
        apply_reset();
        wait_valid("wait_first_valid");
        chk(32'(cs_start - rst_cyc), 32'(PERIOD), "first_cs_fall_cycle");

        // Extreme data values with random framing garbage.
        model_data = 8'h00;
        wait_valid("wait_valid_00");
        model_data = 8'hFF;
        wait_valid("wait_valid_ff");

        // Dropping enable mid-frame lets the frame complete.
        model_data = 8'h3C;
        f0 = frame_num;
        budget = 2 * PERIOD;
        while (frame_num == f0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        chk(32'(frame_num), 32'(f0 + 1), "frame_start_before_disable");
        enable = 1'b0;
        wait_valid("wait_valid_after_disable");

        // No frames for three periods while disabled; restart on a counter wrap.
        f0 = frame_num;
        repeat (3 * PERIOD) @(negedge clock);
        chk(32'(frame_num), 32'(f0), "no_frames_while_disabled");
        chk(32'(als_if.cs), 32'd1, "cs_idle_while_disabled");
        enable     = 1'b1;
        model_data = 8'h5A;
        wait_valid("wait_valid_reenabled");
        chk(32'((cs_start - rst_cyc) % PERIOD), 32'd0, "restart_on_wrap");

        // Reset at the 8th sck rise: pins release next cycle, frame discarded.
        model_data = 8'h77;
        f0 = frame_num;
        budget = 2 * PERIOD;
        while (!(frame_num != f0 && rises >= 8) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        chk(32'(rises), 32'd8, "reached_8th_rise");
        abort_frame = frame_num;
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
        @(negedge clock);
        chk(32'(als_if.cs), 32'd1, "midframe_reset_cs");
        chk(32'(als_if.sck), 32'd1, "midframe_reset_sck");
        chk(32'(als_if.sample), 32'd0, "midframe_reset_sample");
        chk(32'(als_if.sample_valid), 32'd0, "midframe_reset_valid");
        apply_reset();

        // Clean frames after reset with a constant level (averaging ramp).
        model_data = 8'h80;
        wait_valid("wait_valid_80_0");
        chk(32'(cs_start - rst_cyc), 32'(PERIOD), "cs_fall_after_reset");
        for (int k = 1; k < 5; k++) wait_valid("wait_valid_80");

        repeat (10) @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
